// File: rtl/sensor_conditioner_if.sv
// Signal bundle between the loop-detector front end and the light controller:
// raw loop inputs and counter clear in, conditioned demand, arrivals and counts out.
interface sensor_conditioner_if #(
  parameter int CNT_WIDTH = 8
);
  logic                 main_loop_raw;
  logic                 side_loop_raw;
  logic                 count_clr;
  logic                 main_sensor;
  logic                 side_sensor;
  logic                 main_arrival;
  logic                 side_arrival;
  logic [CNT_WIDTH-1:0] main_count;
  logic [CNT_WIDTH-1:0] side_count;

  modport master (
    output main_loop_raw, side_loop_raw, count_clr,
    input  main_sensor, side_sensor, main_arrival, side_arrival, main_count, side_count
  );

  modport slave (
    input  main_loop_raw, side_loop_raw, count_clr,
    output main_sensor, side_sensor, main_arrival, side_arrival, main_count, side_count
  );
endinterface

// File: rtl/sensor_conditioner.sv
// Two independent loop-detector channels: synchronize, debounce, extend presence
// with a hold timer, and count vehicle arrivals with saturation.
module sensor_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int HOLD_CYCLES     = 5,
  parameter int CNT_WIDTH       = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  sensor_conditioner_if.slave  bus
);

  localparam logic [3:0]           DB_LAST   = 4'(DEBOUNCE_CYCLES - 1);
  localparam logic [4:0]           HOLD_LOAD = 5'(HOLD_CYCLES);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);

  // Channel 0 is the main road, channel 1 the side road; nothing is shared.
  for (genvar c = 0; c < 2; c++) begin : g_ch
    logic                 raw;
    logic                 sync1, sync2;
    logic                 db, db_next;
    logic [3:0]           db_cnt, db_cnt_next;
    logic [4:0]           hold_cnt, hold_next;
    logic                 rise, fall;
    logic                 sensor, arrival;
    logic [CNT_WIDTH-1:0] count, count_next;

    assign raw = (c == 0) ? bus.main_loop_raw : bus.side_loop_raw;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
      db_next     = db;
      db_cnt_next = '0;
      if (sync2 != db) begin
        if (db_cnt == DB_LAST) db_next     = ~db;
        else                   db_cnt_next = db_cnt + 4'd1;
      end

      rise = db_next & ~db;
      fall = ~db_next & db;

      hold_next = hold_cnt;
      if (rise)                 hold_next = '0;
      else if (fall)            hold_next = HOLD_LOAD;
      else if (hold_cnt != '0)  hold_next = hold_cnt - 5'd1;

      // A clear on the arrival edge still records that arrival.
      count_next = count;
      if (bus.count_clr)                 count_next = rise ? CNT_ONE : '0;
      else if (rise && count != CNT_MAX) count_next = count + CNT_ONE;
    end

    // NOTE: every flop, counters included, clears asynchronously so a reset
    // mid-debounce or mid-hold leaves no residue and the next rise pays full latency.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        sync1    <= 1'b0;
        sync2    <= 1'b0;
        db       <= 1'b0;
        db_cnt   <= '0;
        hold_cnt <= '0;
        sensor   <= 1'b0;
        arrival  <= 1'b0;
        count    <= '0;
      end else begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        sync1    <= raw;
        sync2    <= sync1;
        db       <= db_next;
        db_cnt   <= db_cnt_next;
        hold_cnt <= hold_next;
        sensor   <= db_next | (hold_next != '0);
        arrival  <= rise;
        count    <= count_next;
      end
    end
  end

  assign bus.main_sensor  = g_ch[0].sensor;
  assign bus.main_arrival = g_ch[0].arrival;
  assign bus.main_count   = g_ch[0].count;
  assign bus.side_sensor  = g_ch[1].sensor;
  assign bus.side_arrival = g_ch[1].arrival;
  assign bus.side_count   = g_ch[1].count;

endmodule

// File: tb/tb_sensor_conditioner.sv
// Directed bench for sensor_conditioner (D=4, H=5, CNT_WIDTH=8): a per-cycle
// vector table plus hand-written hold, saturation and reset sequences.
module tb_sensor_conditioner;
  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  bit   drop;
  int   arr;

  sensor_conditioner_if #(.CNT_WIDTH(8)) bus ();

  sensor_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .HOLD_CYCLES    (5),
    .CNT_WIDTH      (8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        m;
    logic        s;
    logic        clr;
    logic [19:0] exp;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [19:0] pk(logic ms, logic ss, logic ma, logic sa, logic [7:0] mc, logic [7:0] sc);
    return {ms, ss, ma, sa, mc, sc};
  endfunction

  function automatic logic [19:0] outs();
    return {bus.main_sensor, bus.side_sensor, bus.main_arrival, bus.side_arrival,
            bus.main_count, bus.side_count};
  endfunction

  task automatic check(input string name, input logic [19:0] act, input logic [19:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Ticks while recording any main_sensor gap and main arrival pulses.
  task automatic watch(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      if (!bus.main_sensor) drop = 1'b1;
      if (bus.main_arrival) arr++;
    end
  endtask

  task automatic side_pulse();
    bus.side_loop_raw = 1'b1;
    ticks(6);
    bus.side_loop_raw = 1'b0;
    ticks(6);
  endtask

  task automatic row(input bit m, input bit s, input bit clr, input bit ms, input bit ss,
                     input bit ma, input bit sa, input int mc, input int sc);
    vec_t v;
    v.m   = m;
    v.s   = s;
    v.clr = clr;
    v.exp = pk(ms, ss, ma, sa, 8'(mc), 8'(sc));
    tbl.push_back(v);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    bit seen;

    rst               = 1'b1;
    bus.main_loop_raw = 1'b0;
    bus.side_loop_raw = 1'b0;
    bus.count_clr     = 1'b0;
    ticks(2);
    check("reset_state", outs(), '0);
    rst = 1'b0;

    // Main rises (arrival on 6th edge); side 3-cycle glitch ignored, then a
    // 4-cycle side pulse accepted while main falls into its hold window.
    repeat (3) row(1, 1, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) row(1, 0, 0, 0, 0, 0, 0, 0, 0);
    row(1, 0, 0, 1, 0, 1, 0, 1, 0);
    repeat (2) row(1, 0, 0, 1, 0, 0, 0, 1, 0);
    repeat (4) row(0, 1, 0, 1, 0, 0, 0, 1, 0);
    row(0, 0, 0, 1, 0, 0, 0, 1, 0);
    row(0, 0, 0, 1, 1, 0, 1, 1, 1);
    repeat (4) row(0, 0, 0, 1, 1, 0, 0, 1, 1);
    repeat (4) row(0, 0, 0, 0, 1, 0, 0, 1, 1);
    repeat (2) row(0, 0, 0, 0, 0, 0, 0, 1, 1);
    row(0, 0, 1, 0, 0, 0, 0, 0, 0);
    row(0, 0, 0, 0, 0, 0, 0, 0, 0);

    foreach (tbl[i]) begin
      bus.main_loop_raw = tbl[i].m;
      bus.side_loop_raw = tbl[i].s;
      bus.count_clr     = tbl[i].clr;
      tick();
      check($sformatf("vec%0d", i), outs(), tbl[i].exp);
    end
    bus.count_clr = 1'b0;

    // Main 3-cycle glitch must leave no trace.
    seen = 1'b0;
    bus.main_loop_raw = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      seen |= bus.main_sensor | bus.main_arrival;
    end
    bus.main_loop_raw = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      seen |= bus.main_sensor | bus.main_arrival;
    end
    check("main_glitch_seen", 20'(seen), 20'd0);
    check("main_glitch_count", 20'(bus.main_count), 20'd0);

    // Vehicle arrives; bounded wait for the pulse.
    seen = 1'b0;
    bus.main_loop_raw = 1'b1;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      seen = bus.main_arrival;
    end
    check("main_arrival_seen", 20'(seen), 20'd1);
    check("main_count_first", 20'(bus.main_count), 20'd1);
    ticks(3);

    // 3-cycle dropout: no debounce fall, no hold reload, no count.
    drop = 1'b0; arr = 0;
    bus.main_loop_raw = 1'b0;
    watch(3);
    bus.main_loop_raw = 1'b1;
    watch(12);
    check("short_dropout_gap", 20'(drop), 20'd0);
    check("short_dropout_arrivals", 20'(arr), 20'd0);
    check("short_dropout_count", 20'(bus.main_count), 20'd1);

    // 4-cycle dropout: db falls, re-rises inside hold; sensor continuous.
    drop = 1'b0; arr = 0;
    bus.main_loop_raw = 1'b0;
    watch(4);
    bus.main_loop_raw = 1'b1;
    watch(12);
    check("rerise_gap", 20'(drop), 20'd0);
    check("rerise_arrivals", 20'(arr), 20'd1);
    check("rerise_count", 20'(bus.main_count), 20'd2);

    // Final departure: sensor drops on the 11th edge after raw falls.
    bus.main_loop_raw = 1'b0;
    ticks(10);
    check("hold_last_cycle", 20'(bus.main_sensor), 20'd1);
    tick();
    check("hold_expired", 20'(bus.main_sensor), 20'd0);

    // Side count saturation.
    for (int i = 0; i < 254; i++) side_pulse();
    check("side_count_254", 20'(bus.side_count), 20'd254);
    for (int i = 0; i < 3; i++) begin
      side_pulse();
      check($sformatf("side_count_sat%0d", i), 20'(bus.side_count), 20'd255);
    end
    check("main_count_indep", 20'(bus.main_count), 20'd2);

    // Clear coincident with an arrival edge leaves the count at 1.
    bus.side_loop_raw = 1'b1;
    ticks(5);
    check("side_pre_arrival", 20'(bus.side_arrival), 20'd0);
    bus.count_clr = 1'b1;
    tick();
    check("clr_with_arrival", {18'd0, bus.side_arrival, 1'b0} | 20'(bus.side_count), 20'd3);
    check("clr_main_count", 20'(bus.main_count), 20'd0);
    bus.count_clr = 1'b0;
    tick();
    check("after_clr", {18'd0, bus.side_arrival, 1'b0} | 20'(bus.side_count), 20'd1);

    // Reset during side hold and main debounce count 2.
    ticks(3);
    bus.side_loop_raw = 1'b0;
    ticks(2);
    bus.main_loop_raw = 1'b1;
    ticks(4);
    check("pre_reset_state", 20'({bus.main_sensor, bus.side_sensor}), 20'b01);
    #2 rst = 1'b1;
    #1 check("reset_async", outs(), '0);
    tick();
    check("reset_held", outs(), '0);
    rst = 1'b0;
    ticks(5);
    check("post_reset_edge5", outs(), '0);
    tick();
    check("post_reset_rise", outs(), pk(1, 0, 1, 0, 1, 0));
    tick();
    check("post_reset_steady", outs(), pk(1, 0, 0, 0, 1, 0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
